// File: rtl/hc595_serializer.sv
// Shifts one parallel word MSB-first into a 74HC595 chain, then pulses RCLK to latch it.
// Optional power-up clear of the chain outputs is enabled with `define HC595_CLEAR_EN.
module hc595_serializer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 1200
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             sclk,
    output logic             rclk,
    output logic             serial_data,
    output logic             _srclr
);

    // CLK_DIV=1 still needs a one-bit counter so the tick compare is well formed
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_LATCH  = 3'd2
`ifdef HC595_CLEAR_EN
        ,
        S_PRECLR = 3'd3,
        S_CLEAR  = 3'd4
`endif
    } state_t;

`ifdef HC595_CLEAR_EN
    localparam state_t RST_STATE = S_PRECLR;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-2:0] shreg;
    logic             tick_c;

    assign tick_c = (tick_cnt == TICK_MAX);

`ifndef HC595_CLEAR_EN
    assign _srclr = 1'b1;
`endif

    // Shift sequencer: serial_data changes on the SCLK fall, so it is stable a full tick around each rise
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state       <= RST_STATE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            in_ready    <= RST_READY;
            busy        <= 1'b0;
            sclk        <= 1'b0;
            rclk        <= 1'b0;
            serial_data <= 1'b0;
`ifdef HC595_CLEAR_EN
            _srclr      <= 1'b1;
`endif
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (in_valid && in_ready) begin
                        shreg       <= in_data[WIDTH-2:0];
                        serial_data <= in_data[WIDTH-1];
                        bit_cnt     <= BIT_MAX;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (tick_c) begin
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk    <= 1'b0;
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - BIT_W'(1);
                            if (bit_cnt == '0) begin
                                serial_data <= 1'b0;
                                rclk        <= 1'b1;
                                state       <= S_LATCH;
                            end else begin
                                serial_data <= shreg[WIDTH-2];
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (tick_c) begin
                        rclk     <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
`ifdef HC595_CLEAR_EN
                S_PRECLR: begin
                    tick_cnt <= '0;
                    _srclr   <= 1'b0;
                    busy     <= 1'b1;
                    state    <= S_CLEAR;
                end
                // Release SRCLR and latch the now-empty shift register; LATCH finishes the pulse
                S_CLEAR: begin
                    if (tick_c) begin
                        _srclr <= 1'b1;
                        rclk   <= 1'b1;
                        state  <= S_LATCH;
                    end
                end
`endif
                default: begin
                    tick_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_serializer.sv
// Scoreboard bench for hc595_serializer: one instance at CLK_DIV=4 and one at CLK_DIV=1.
// Expected words and their acceptance cycles are queued by the driver; the monitor derives timing from them.
`timescale 1ns/1ps
module tb_hc595_serializer;

    localparam int W  = 16;
    localparam int D0 = 4;
    localparam int D1 = 1;
`ifdef HC595_CLEAR_EN
    localparam logic RST_RDY = 1'b0;
`else
    localparam logic RST_RDY = 1'b1;
`endif

    typedef struct {
        logic [W-1:0] word;
        int           acc;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0_n, rst1_n;
    logic [W-1:0] d0, d1;
    logic         v0, v1;
    logic         rdy0, busy0, sclk0, rclk0, sd0, srclr0;
    logic         rdy1, busy1, sclk1, rclk1, sd1, srclr1;

    hc595_serializer #(.WIDTH(W), .CLK_DIV(D0)) u_dut0 (
        .clk(clk), ._rst(rst0_n), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
        .busy(busy0), .sclk(sclk0), .rclk(rclk0), .serial_data(sd0), ._srclr(srclr0)
    );

    hc595_serializer #(.WIDTH(W), .CLK_DIV(D1)) u_dut1 (
        .clk(clk), ._rst(rst1_n), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
        .busy(busy1), .sclk(sclk1), .rclk(rclk1), .serial_data(sd1), ._srclr(srclr1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    item_t q0[$];
    item_t q1[$];
    int nexp[2];

    // monitor state per instance
    int           bi[2];
    logic [W-1:0] got[2];
    logic         ps[2], pr[2], pclr[2], in_latch[2];
    int           lacc[2];
    int           latched[2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {in_ready, busy, sclk, rclk, serial_data, _srclr}
    function automatic logic [5:0] outs(input int u);
        return (u == 0) ? {rdy0, busy0, sclk0, rclk0, sd0, srclr0}
                        : {rdy1, busy1, sclk1, rclk1, sd1, srclr1};
    endfunction

    function automatic int div_of(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    task automatic drive(input int u, input logic v, input logic [W-1:0] d);
        if (u == 0) begin v0 = v; d0 = d; end
        else        begin v1 = v; d1 = d; end
    endtask

    task automatic flush(input int u);
        if (u == 0) q0.delete(); else q1.delete();
    endtask

    task automatic mon(input int u, input logic rst_n, input logic [5:0] o);
        logic  rdy, bsy, s, r, sd, clr;
        int    p, d, n;
        item_t f;
        {rdy, bsy, s, r, sd, clr} = o;
        if (!rst_n) begin
            bi[u] = 0; got[u] = '0; ps[u] = 1'b0; pr[u] = 1'b0; pclr[u] = 1'b1; in_latch[u] = 1'b0;
            return;
        end
        p = cyc;
        d = div_of(u);
        n = (u == 0) ? q0.size() : q1.size();
        f.word = '0; f.acc = 0;
        if (n > 0) f = (u == 0) ? q0[0] : q1[0];

        chk($sformatf("u%0d ready_with_rclk", u), rdy && r, 0);
        chk($sformatf("u%0d ready_with_busy", u), rdy && bsy, 0);
        if (n > 0 && p >= f.acc) chk($sformatf("u%0d ready_in_flight", u), rdy, 0);
        if (r && pr[u]) chk($sformatf("u%0d sclk_edge_in_rclk", u), s, ps[u]);
`ifndef HC595_CLEAR_EN
        chk($sformatf("u%0d srclr_const", u), clr, 1);
`endif

        if (s && !ps[u]) begin
            if (n == 0 || p < f.acc || bi[u] >= W) begin
                chk($sformatf("u%0d sclk_rise_unexpected", u), 1, 0);
            end else begin
                chk($sformatf("u%0d bit%0d_rise_time", u, bi[u]), p - f.acc, (2 * bi[u] + 1) * d);
                chk($sformatf("u%0d bit%0d_data", u, bi[u]), sd, f.word[W-1-bi[u]]);
                got[u] = {got[u][W-2:0], sd};
                bi[u]++;
            end
        end
        if (!s && ps[u] && n > 0)
            chk($sformatf("u%0d bit%0d_fall_time", u, bi[u] - 1), p - f.acc, 2 * bi[u] * d);

        if (r && !pr[u]) begin
            if (n == 0 && !pclr[u] && clr) begin
                // power-up clear latch, checked by the reset sequence
            end else if (n == 0 || p < f.acc) begin
                chk($sformatf("u%0d rclk_unexpected", u), 1, 0);
            end else begin
                chk($sformatf("u%0d rclk_rise_time", u), p - f.acc, 2 * W * d);
                chk($sformatf("u%0d bits_shifted", u), bi[u], W);
                chk($sformatf("u%0d word", u), got[u], f.word);
                lacc[u] = f.acc;
                in_latch[u] = 1'b1;
                latched[u]++;
                if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                bi[u] = 0;
                got[u] = '0;
            end
        end
        if (!r && pr[u] && in_latch[u]) begin
            chk($sformatf("u%0d rclk_fall_time", u), p - lacc[u], (2 * W + 1) * d);
            chk($sformatf("u%0d ready_at_rclk_fall", u), rdy, 1);
            in_latch[u] = 1'b0;
        end
        ps[u] = s; pr[u] = r; pclr[u] = clr;
    endtask

    always @(negedge clk) begin
        mon(0, rst0_n, outs(0));
        mon(1, rst1_n, outs(1));
    end

    // Assert reset, check reset values, release and check the post-reset sequence
    task automatic reset_seq(input int u);
        logic [5:0] o;
        int d;
        d = div_of(u);
        if (u == 0) rst0_n = 1'b0; else rst1_n = 1'b0;
        flush(u);
        repeat (2) @(negedge clk);
        o = outs(u);
        chk($sformatf("u%0d rst_ready", u), o[5], RST_RDY);
        chk($sformatf("u%0d rst_busy", u), o[4], 0);
        chk($sformatf("u%0d rst_sclk", u), o[3], 0);
        chk($sformatf("u%0d rst_rclk", u), o[2], 0);
        chk($sformatf("u%0d rst_sdata", u), o[1], 0);
        chk($sformatf("u%0d rst_srclr", u), o[0], 1);
        if (u == 0) rst0_n = 1'b1; else rst1_n = 1'b1;
`ifdef HC595_CLEAR_EN
        for (int t = 1; t <= 2 * d + 1; t++) begin
            @(negedge clk);
            o = outs(u);
            chk($sformatf("u%0d clr_srclr t%0d", u, t), o[0], (t > d) ? 1 : 0);
            chk($sformatf("u%0d clr_rclk t%0d", u, t), o[2], (t > d && t <= 2 * d) ? 1 : 0);
            chk($sformatf("u%0d clr_ready t%0d", u, t), o[5], (t == 2 * d + 1) ? 1 : 0);
        end
`else
        @(negedge clk);
        chk($sformatf("u%0d ready_after_reset d%0d", u, d), outs(u) >> 5, 1);
`endif
    endtask

    // Present a word from a negedge; returns at the negedge after acceptance with in_valid still high
    task automatic send(input int u, input logic [W-1:0] w, output int acc);
        item_t it;
        acc = -1;
        drive(u, 1'b1, w);
        for (int t = 0; t < 2000; t++) begin
            if (outs(u) >> 5 != 0) begin
                acc = cyc + 1;
                it.word = w;
                it.acc  = acc;
                if (u == 0) q0.push_back(it); else q1.push_back(it);
                nexp[u]++;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk($sformatf("u%0d accept_timeout", u), 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int u);
        int t;
        for (t = 0; t < 2000; t++) begin
            if (outs(u) >> 5 != 0) break;
            @(negedge clk);
        end
        if (t == 2000) chk($sformatf("u%0d idle_timeout", u), 1, 0);
    endtask

    // Random valid/data activity while the word is being shifted
    task automatic noise(input int u);
        for (int t = 0; t < 2000; t++) begin
            if (((outs(u) >> 4) & 6'd1) == 0) break;
            drive(u, 1'($urandom_range(0, 1)), W'($urandom));
            @(negedge clk);
        end
        drive(u, 1'b0, '0);
    endtask

    initial begin
        int a, a2;
        rst0_n = 1'b0; rst1_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        nexp[0] = 0; nexp[1] = 0; latched[0] = 0; latched[1] = 0;
        repeat (2) @(negedge clk);
        reset_seq(0);
        reset_seq(1);

        // single word
        send(0, 16'hA5C3, a);
        drive(0, 1'b0, '0);
        wait_idle(0);

        // back-to-back with in_valid held
        send(0, 16'hFFFF, a);
        send(0, 16'h0001, a2);
        drive(0, 1'b0, '0);
        chk("u0 b2b_gap", a2 - a, (2 * W + 1) * D0 + 1);
        wait_idle(0);

        // random words with handshake noise while busy
        repeat (4) begin
            send(0, W'($urandom), a);
            noise(0);
            wait_idle(0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset 50 cycles into a word
        send(0, 16'hBEEF, a);
        drive(0, 1'b0, '0);
        while (cyc < a + 50) begin
            @(posedge clk);
            #1;
        end
        rst0_n = 1'b0;
        flush(0);
        nexp[0]--;
        #1;
        chk("u0 midrst_sclk", sclk0, 0);
        chk("u0 midrst_rclk", rclk0, 0);
        chk("u0 midrst_sdata", sd0, 0);
        chk("u0 midrst_busy", busy0, 0);
        chk("u0 midrst_ready", rdy0, RST_RDY);
        chk("u0 midrst_srclr", srclr0, 1);
        @(negedge clk);
        reset_seq(0);
        send(0, 16'h1234, a);
        drive(0, 1'b0, '0);
        wait_idle(0);

        // CLK_DIV=1 instance
        send(1, 16'h8001, a);
        send(1, 16'h8001, a2);
        drive(1, 1'b0, '0);
        chk("u1 b2b_gap", a2 - a, (2 * W + 1) * D1 + 1);
        wait_idle(1);
        repeat (3) begin
            send(1, W'($urandom), a);
            noise(1);
            wait_idle(1);
        end

        repeat (3) @(negedge clk);
        chk("u0 queue_empty", q0.size(), 0);
        chk("u1 queue_empty", q1.size(), 0);
        chk("u0 latched_count", latched[0], nexp[0]);
        chk("u1 latched_count", latched[1], nexp[1]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
